// File: rtl/obc_slice_accumulator.sv
// Bit-serial front/back end for the OBC DFT ROM stage: streams 16 samples out
// one bit-slice per cycle (LSB first) and shift-accumulates the ROM results.

module obc_slice_lane #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         lsb
);
    logic [W-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        sr <= '0;
        else if (load)  sr <= din;
        else if (shift) sr <= sr >> 1;
    end

    assign lsb = sr[0];
endmodule

module obc_slice_accumulator #(
    parameter int W     = 8,
    parameter int ACC_W = 40
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [16*W-1:0]         x_in,
    input  logic [31:0]             offset_in,
    output logic                    busy,
    output logic [15:0]             slice_out,
    output logic                    m_out,
    input  logic [31:0]             rom_in,
    output logic signed [ACC_W-1:0] acc_out,
    output logic                    out_valid,
    input  logic                    out_ready
);
    localparam int NUM_LANES = 16;
    localparam int B_W       = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                 state, state_nxt;
    logic [B_W-1:0]         b;
    logic signed [ACC_W-1:0] acc, acc_nxt, rom_ext;
    logic                   load, shift_en, last;
    logic [NUM_LANES-1:0]   lane_lsb;

    genvar k;
    generate
        for (k = 0; k < NUM_LANES; k++) begin : g_lane
            obc_slice_lane #(.W(W)) u_lane (
                .clk   (clk),
                .rst   (rst),
                .load  (load),
                .shift (shift_en),
                .din   (x_in[k*W +: W]),
                .lsb   (lane_lsb[k])
            );
        end
    endgenerate

    assign last = (b == B_W'(W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift_en  = 1'b0;
        case (state)
            IDLE: if (start) begin
                load      = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ROM already applies the sign step on the MSB slice; only weight by 2^b here.
    assign rom_ext = {{(ACC_W-32){rom_in[31]}}, rom_in};
    assign acc_nxt = acc + (rom_ext << b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            acc_out <= '0;
            b       <= '0;
        end else if (load) begin
            acc <= {{(ACC_W-32){offset_in[31]}}, offset_in};
            b   <= '0;
        end else if (shift_en) begin
            acc <= acc_nxt;
            b   <= last ? '0 : b + 1'b1;
            if (last) acc_out <= acc_nxt;
        end
    end

    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign m_out     = (state == SHIFT) && last;
    assign slice_out = (state == SHIFT) ? lane_lsb : '0;
endmodule

// File: tb/tb_obc_slice_accumulator.sv
// Randomized bench for obc_slice_accumulator with a behavioural OBC ROM stage
// and a direct-DFT golden model.

module tb_obc_slice_accumulator;
    localparam int W     = 8;
    localparam int ACC_W = 40;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [16*W-1:0]         x_in;
    logic [31:0]             offset_in;
    logic                    busy;
    logic [15:0]             slice_out;
    logic                    m_out;
    logic [31:0]             rom_in;
    logic signed [ACC_W-1:0] acc_out;
    logic                    out_valid;
    logic                    out_ready;

    int total = 0;
    int bad   = 0;
    int mode  = 0;
    int coef [16];

    obc_slice_accumulator #(.W(W), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .x_in      (x_in),
        .offset_in (offset_in),
        .busy      (busy),
        .slice_out (slice_out),
        .m_out     (m_out),
        .rom_in    (rom_in),
        .acc_out   (acc_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Behavioural ROM stage: OBC digits d = 2*bit-1, negated on the sign step.
    always_comb begin
        int s;
        s = 0;
        case (mode)
            1: s = 1;
            2: s = slice_out[0] ? 1 : 0;
            5: for (int k = 0; k < 16; k++) s += slice_out[k] ? coef[k] : -coef[k];
            6: s = 32'h7FFFFFFF;
            default: s = 0;
        endcase
        if (mode != 6 && m_out) s = -s;
        rom_in = s;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16*W-1:0] rand_x();
        logic [16*W-1:0] v;
        for (int k = 0; k < 16; k++) v[k*W +: W] = W'($urandom);
        return v;
    endfunction

    function automatic longint sx(input logic [W-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic logic [63:0] m_acc(input longint v);
        logic [63:0] t;
        t = 64'(v);
        return {{(64-ACC_W){1'b0}}, t[ACC_W-1:0]};
    endfunction

    task automatic launch(input logic [16*W-1:0] xs, input logic [31:0] off);
        x_in      = xs;
        offset_in = off;
        start     = 1'b1;
        step();
        start     = 1'b0;
        x_in      = rand_x();
        offset_in = $urandom;
        chk("busy_on_start", 64'(busy), 64'd1);
    endtask

    task automatic shift_phase(input logic [16*W-1:0] xs);
        logic [15:0] sl;
        for (int c = 0; c < W; c++) begin
            for (int k = 0; k < 16; k++) sl[k] = xs[k*W + c];
            chk("slice", 64'(slice_out), 64'(sl));
            chk("m_out", 64'(m_out), 64'(c == W - 1));
            chk("valid_early", 64'(out_valid), 64'd0);
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        out_ready = 1'b0;
        chk("valid_latency", 64'(out_valid), 64'd1);
    endtask

    task automatic drain(input longint exp);
        chk("acc", 64'(acc_out) & m_acc(-1), m_acc(exp));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("valid_drop", 64'(out_valid), 64'd0);
        chk("busy_drop", 64'(busy), 64'd0);
        chk("acc_hold", 64'(acc_out) & m_acc(-1), m_acc(exp));
    endtask

    initial begin
        logic [16*W-1:0] xs;
        logic [31:0]     off;
        longint          exp, dot, csum;
        int              n, seen;
        int              sin_t [16] = '{0, 392, 724, 946, 1024, 946, 724, 392,
                                        0, -392, -724, -946, -1024, -946, -724, -392};

        rst = 1'b1; start = 1'b0; out_ready = 1'b0; x_in = '0; offset_in = '0;
        repeat (3) step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_slice", 64'(slice_out), 64'd0);
        chk("rst_m", 64'(m_out), 64'd0);
        chk("rst_acc", 64'(acc_out) & m_acc(-1), 64'd0);
        rst = 1'b0;
        step();

        // +1 per slice, -1 on the sign step
        mode = 1;
        xs = rand_x();
        launch(xs, 32'd0);
        shift_phase(xs);
        drain((longint'(1) << (W - 1)) - 1 - (longint'(1) << (W - 1)));

        // Single-lane reconstruction: acc = offset + signed sample 0
        mode = 2;
        for (int i = 0; i < 30; i++) begin
            xs  = (i == 0) ? {{(15*W){1'b0}}, W'(8'hA5)} : rand_x();
            off = (i == 0) ? 32'd5 : $urandom;
            launch(xs, off);
            shift_phase(xs);
            drain(longint'($signed(off)) + sx(xs[W-1:0]));
        end

        // Stalled result: start ignored, output stable, then immediate restart
        xs = rand_x(); off = $urandom;
        exp = longint'($signed(off)) + sx(xs[W-1:0]);
        launch(xs, off);
        shift_phase(xs);
        for (int i = 0; i < 10; i++) begin
            start = 1'b1;
            x_in  = rand_x();
            step();
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_acc", 64'(acc_out) & m_acc(-1), m_acc(exp));
        end
        start = 1'b0;
        drain(exp);
        xs = rand_x(); off = $urandom;
        launch(xs, off);
        shift_phase(xs);
        drain(longint'($signed(off)) + sx(xs[W-1:0]));

        // Asynchronous reset during slice b=3
        launch(rand_x(), $urandom);
        repeat (3) step();
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_slice", 64'(slice_out), 64'd0);
        chk("arst_m", 64'(m_out), 64'd0);
        chk("arst_acc", 64'(acc_out) & m_acc(-1), 64'd0);
        step();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 3 * W; i++) begin
            step();
            if (out_valid || busy) seen++;
        end
        chk("arst_no_result", 64'(seen), 64'd0);

        // Imaginary DFT bin through the OBC ROM stage
        mode = 5;
        for (int i = 0; i < 200; i++) begin
            n = $urandom_range(0, 15);
            csum = 0;
            for (int k = 0; k < 16; k++) begin
                coef[k] = -sin_t[(k * n) % 16];
                csum += coef[k];
            end
            xs  = rand_x();
            dot = 0;
            for (int k = 0; k < 16; k++) dot += longint'(coef[k]) * sx(xs[k*W +: W]);
            launch(xs, 32'(-csum));
            shift_phase(xs);
            drain(2 * dot);
        end

        // Large constant ROM output and offset
        mode = 6;
        xs = rand_x();
        launch(xs, 32'h7FFFFFFF);
        shift_phase(xs);
        drain(longint'(32'h7FFFFFFF) * (longint'(1) << W));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
